// File: rtl/vga_timing_param.sv
// Parametrised VGA timing generator: pixel-tick divider, h/v counters, sync/valid delay line.
// Optional frame counter is enabled by defining VGA_FRAME_CNT_EN.
module vga_timing_param #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned SYNC_POL = 0,
  parameter int unsigned PIPE_DLY = 0,
  parameter int unsigned CNT_W    = 10,
  parameter int unsigned FRM_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic             pix_tick,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt,
  output logic             hsync,
  output logic             vsync,
  output logic             valid,
  output logic             line_start,
  output logic             frame_start,
  output logic [FRM_W-1:0] frame_cnt
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_BEG  = H_ACTIVE + H_FP;
  localparam int unsigned HS_END  = HS_BEG + H_SYNC - 1;
  localparam int unsigned VS_BEG  = V_ACTIVE + V_FP;
  localparam int unsigned VS_END  = VS_BEG + V_SYNC - 1;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic        ACT     = 1'(SYNC_POL);

  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic             h_wrap;
  logic             v_wrap;
  logic [CNT_W-1:0] h_next;
  logic [CNT_W-1:0] v_next;
  logic [2:0]       sig_next;   // {hs, vs, va} decoded from the next count
  logic [2:0]       sig_r;
  logic [2:0]       sig_out;
  logic             ls_r;
  logic             fs_r;

  // Terminal count is gated by en and rst so a suppressed tick never leaks out.
  assign tick     = en & ~rst & (div_cnt == DIV_W'(CLK_DIV - 1));
  assign pix_tick = tick;
  assign h_wrap   = (h_cnt == CNT_W'(H_TOTAL - 1));
  assign v_wrap   = (v_cnt == CNT_W'(V_TOTAL - 1));

  always_comb begin
    h_next = h_wrap ? '0 : h_cnt + 1'b1;
    v_next = v_cnt;
    if (h_wrap) begin
      v_next = v_wrap ? '0 : v_cnt + 1'b1;
    end
    sig_next[2] = (h_next >= CNT_W'(HS_BEG)) && (h_next <= CNT_W'(HS_END));
    sig_next[1] = (v_next >= CNT_W'(VS_BEG)) && (v_next <= CNT_W'(VS_END));
    sig_next[0] = (h_next < CNT_W'(H_ACTIVE)) && (v_next < CNT_W'(V_ACTIVE));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      h_cnt   <= '0;
      v_cnt   <= '0;
      sig_r   <= '0;
    end else if (en) begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick) begin
        h_cnt <= h_next;
        v_cnt <= v_next;
        sig_r <= sig_next;
      end
    end
  end

  // Wrap strobes land one clk after the wrapping tick; en low masks them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ls_r <= 1'b0;
      fs_r <= 1'b0;
    end else begin
      ls_r <= tick & h_wrap;
      fs_r <= tick & h_wrap & v_wrap;
    end
  end

  assign line_start  = ls_r & en;
  assign frame_start = fs_r & en;

  generate
    if (PIPE_DLY == 0) begin : g_nodly
      assign sig_out = sig_r;
    end else begin : g_dly
      logic [2:0] dly [PIPE_DLY];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < int'(PIPE_DLY); i++) dly[i] <= '0;
        end else if (tick) begin
          dly[0] <= sig_r;
          for (int i = 1; i < int'(PIPE_DLY); i++) dly[i] <= dly[i-1];
        end
      end

      assign sig_out = dly[PIPE_DLY-1];
    end
  endgenerate

  assign hsync = sig_out[2] ? ACT : ~ACT;
  assign vsync = sig_out[1] ? ACT : ~ACT;
  assign valid = sig_out[0];

`ifdef VGA_FRAME_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= '0;
    end else if (tick & h_wrap & v_wrap) begin
      frame_cnt <= frame_cnt + 1'b1;
    end
  end
`else
  assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_vga_timing_param.sv
// Bench for vga_timing_param: default-timing instance, small PIPE_DLY=3/active-high instance
// with a cycle scoreboard, and a CLK_DIV=1 instance.
module tb_vga_timing_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // ---------------- default instance ----------------
  logic       rst_d, en_d, pt_d, hs_d, vs_d, va_d, ls_d, fs_d;
  logic [9:0] h_d, v_d;
  logic [7:0] fc_d;

  vga_timing_param dut_d (
    .clk(clk), .rst(rst_d), .en(en_d), .pix_tick(pt_d), .h_cnt(h_d), .v_cnt(v_d),
    .hsync(hs_d), .vsync(vs_d), .valid(va_d), .line_start(ls_d), .frame_start(fs_d),
    .frame_cnt(fc_d)
  );

  // ---------------- small instance: 15x8 total, CLK_DIV=2, PIPE_DLY=3, active-high ----------------
  localparam int S_HA = 8, S_HF = 2, S_HS = 3, S_HB = 2;
  localparam int S_VA = 4, S_VF = 1, S_VS = 2, S_VB = 1;
  localparam int S_HT = S_HA + S_HF + S_HS + S_HB;
  localparam int S_VT = S_VA + S_VF + S_VS + S_VB;
  localparam int S_DIV = 2, S_DLY = 3;

  logic       rst_s, en_s, pt_s, hs_s, vs_s, va_s, ls_s, fs_s;
  logic [3:0] h_s, v_s;
  logic [7:0] fc_s;

  vga_timing_param #(
    .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
    .CLK_DIV(S_DIV), .SYNC_POL(1), .PIPE_DLY(S_DLY), .CNT_W(4), .FRM_W(8)
  ) dut_s (
    .clk(clk), .rst(rst_s), .en(en_s), .pix_tick(pt_s), .h_cnt(h_s), .v_cnt(v_s),
    .hsync(hs_s), .vsync(vs_s), .valid(va_s), .line_start(ls_s), .frame_start(fs_s),
    .frame_cnt(fc_s)
  );

  // ---------------- tiny instance: CLK_DIV=1 ----------------
  logic       rst_t, en_t, pt_t, hs_t, vs_t, va_t, ls_t, fs_t;
  logic [2:0] h_t, v_t;
  logic [3:0] fc_t;

  vga_timing_param #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .CLK_DIV(1), .SYNC_POL(0), .PIPE_DLY(1), .CNT_W(3), .FRM_W(4)
  ) dut_t (
    .clk(clk), .rst(rst_t), .en(en_t), .pix_tick(pt_t), .h_cnt(h_t), .v_cnt(v_t),
    .hsync(hs_t), .vsync(vs_t), .valid(va_t), .line_start(ls_t), .frame_start(fs_t),
    .frame_cnt(fc_t)
  );

  // ---------------- scoreboard for the small instance ----------------
  typedef struct packed {
    logic       pt;
    logic [3:0] h;
    logic [3:0] v;
    logic       hs;
    logic       vs;
    logic       va;
    logic       ls;
    logic       fs;
    logic [7:0] fc;
  } obs_t;

  obs_t sbq[$];
  int   m_div = 0, m_h = 0, m_v = 0, m_fc = 0;
  bit   m_ls = 0, m_fs = 0;
  int   hq[$];   // positions (h*64+v) after each of the last S_DLY+1 ticks

  // Model steps on the edge, then predicts what the outputs show for the rest of the cycle.
  always @(posedge clk) begin : sb_model
    obs_t e;
    int   ph, pv;
    bit   ah, av, aa;
    if (rst_s) begin
      m_div = 0; m_h = 0; m_v = 0; m_fc = 0; m_ls = 0; m_fs = 0;
      hq.delete();
    end else if (en_s) begin
      m_ls = 0;
      m_fs = 0;
      if (m_div == S_DIV - 1) begin
        m_div = 0;
        if (m_h == S_HT - 1) begin
          m_h  = 0;
          m_ls = 1;
          if (m_v == S_VT - 1) begin
            m_v  = 0;
            m_fs = 1;
`ifdef VGA_FRAME_CNT_EN
            m_fc = (m_fc + 1) % 256;
`endif
          end else m_v++;
        end else m_h++;
        hq.push_back(m_h * 64 + m_v);
        if (hq.size() > S_DLY + 1) void'(hq.pop_front());
      end else m_div++;
    end else begin
      m_ls = 0;
      m_fs = 0;
    end
    #2;
    ah = 0; av = 0; aa = 0;
    if (hq.size() == S_DLY + 1) begin
      ph = hq[0] / 64;
      pv = hq[0] % 64;
      ah = (ph >= S_HA + S_HF) && (ph < S_HA + S_HF + S_HS);
      av = (pv >= S_VA + S_VF) && (pv < S_VA + S_VF + S_VS);
      aa = (ph < S_HA) && (pv < S_VA);
    end
    e.pt = en_s && !rst_s && (m_div == S_DIV - 1);
    e.h  = 4'(m_h);
    e.v  = 4'(m_v);
    e.hs = ah;
    e.vs = av;
    e.va = aa;
    e.ls = m_ls && en_s;
    e.fs = m_fs && en_s;
    e.fc = 8'(m_fc);
    sbq.push_back(e);
  end

  always @(negedge clk) begin : sb_check
    obs_t e, a;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      a = {pt_s, h_s, v_s, hs_s, vs_s, va_s, ls_s, fs_s, fc_s};
      check("scoreboard {pt,h,v,hs,vs,va,ls,fs,fc}", longint'(a), longint'(e));
    end
  end

  // ---------------- default-instance tasks ----------------
  task automatic chk_reset_d(input string tag);
    check({tag, "_pix_tick"}, pt_d, 0);
    check({tag, "_h_cnt"}, h_d, 0);
    check({tag, "_v_cnt"}, v_d, 0);
    check({tag, "_hsync"}, hs_d, 1);
    check({tag, "_vsync"}, vs_d, 1);
    check({tag, "_valid"}, va_d, 0);
    check({tag, "_line_start"}, ls_d, 0);
    check({tag, "_frame_start"}, fs_d, 0);
    check({tag, "_frame_cnt"}, fc_d, 0);
  endtask

  // Called #1 after the edge that releases reset.
  task automatic first_tick_d(input string tag);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check({tag, "_tick_phase"}, pt_d, (i == 3) ? 1 : 0);
      check({tag, "_h_before_tick"}, h_d, 0);
    end
    @(negedge clk);
    check({tag, "_h_after_tick"}, h_d, 1);
  endtask

  task automatic wait_hv_d(input int h, input int v, input string name);
    int k;
    for (k = 0; k < 4000; k++) begin
      if (h_d == 10'(h) && v_d == 10'(v)) break;
      @(negedge clk);
    end
    if (k == 4000) timeout(name);
  endtask

  typedef struct {
    int   h;
    int   v;
    logic hs;
    logic vs;
    logic va;
  } vec_t;

  task automatic run_default();
    vec_t tbl[11];
    int   per, hl, vc, lc, tc, k, ticks;
    tbl[0]  = '{1,   0, 1'b1, 1'b1, 1'b1};
    tbl[1]  = '{639, 0, 1'b1, 1'b1, 1'b1};
    tbl[2]  = '{640, 0, 1'b1, 1'b1, 1'b0};
    tbl[3]  = '{655, 0, 1'b1, 1'b1, 1'b0};
    tbl[4]  = '{656, 0, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{751, 0, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{752, 0, 1'b1, 1'b1, 1'b0};
    tbl[7]  = '{799, 0, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{0,   1, 1'b1, 1'b1, 1'b1};
    tbl[9]  = '{639, 1, 1'b1, 1'b1, 1'b1};
    tbl[10] = '{640, 1, 1'b1, 1'b1, 1'b0};

    first_tick_d("cold");
    foreach (tbl[i]) begin
      wait_hv_d(tbl[i].h, tbl[i].v, $sformatf("vec%0d_wait", i));
      check($sformatf("vec%0d_hsync", i), hs_d, tbl[i].hs);
      check($sformatf("vec%0d_vsync", i), vs_d, tbl[i].vs);
      check($sformatf("vec%0d_valid", i), va_d, tbl[i].va);
    end

    // One full line between line_start pulses.
    for (k = 0; k < 4000 && !ls_d; k++) @(negedge clk);
    if (k == 4000) timeout("line_start_wait");
    per = 0; hl = 0; vc = 0; lc = 0; tc = 0;
    do begin
      hl += int'(hs_d == 1'b0);
      vc += int'(va_d);
      lc += int'(ls_d);
      tc += int'(pt_d);
      per++;
      @(negedge clk);
    end while (!ls_d && per < 4000);
    check("line_period_clks", per, 3200);
    check("hsync_low_clks", hl, 384);
    check("valid_high_clks", vc, 2560);
    check("line_start_pulses", lc, 1);
    check("pix_ticks_per_line", tc, 800);
    check("wrap_h_cnt", h_d, 0);
    check("wrap_v_cnt", v_d, 3);

    // Freeze for 10 clks at h_cnt=100 with the divider one step in.
    wait_hv_d(100, 3, "hold_wait");
    @(posedge clk);
    #1 en_d = 1'b0;
    ticks = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      ticks += int'(pt_d) + int'(ls_d);
      if (h_d != 10'd100) ticks += 1000;
    end
    check("hold_ticks_and_moves", ticks, 0);
    check("hold_h_cnt", h_d, 100);
    @(posedge clk);
    #1 en_d = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("resume_tick_phase", pt_d, (i == 2) ? 1 : 0);
      check("resume_h_before", h_d, 100);
    end
    @(negedge clk);
    check("resume_h_after", h_d, 101);

    // Asynchronous reset mid-line, checked before the next edge.
    wait_hv_d(400, 3, "areset_wait");
    #1 rst_d = 1'b1;
    #1 chk_reset_d("areset");
    @(posedge clk);
    #1 rst_d = 1'b0;
    first_tick_d("restart");
  endtask

  task automatic run_small();
    int k, nfs, cyc, last;
    for (k = 0; k < 1000; k++) begin
      if (h_s == 4'd5 && v_s == 4'd2) break;
      @(negedge clk);
    end
    if (k == 1000) timeout("s_areset_wait");
    #1 rst_s = 1'b1;
    #1;
    check("s_areset_h", h_s, 0);
    check("s_areset_v", v_s, 0);
    check("s_areset_hsync", hs_s, 0);
    check("s_areset_vsync", vs_s, 0);
    check("s_areset_valid", va_s, 0);
    check("s_areset_pix_tick", pt_s, 0);
    @(posedge clk);
    #1 rst_s = 1'b0;

    for (k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (h_s == 4'd3 && v_s == 4'd1) break;
    end
    if (k == 1000) timeout("s_hold_wait");
    @(posedge clk);
    #1 en_s = 1'b0;
    repeat (7) @(posedge clk);
    #1 en_s = 1'b1;

    nfs = 0; cyc = 0; last = 0;
    for (k = 0; k < 70000; k++) begin
      @(negedge clk);
      cyc++;
      if (fs_s) begin
        nfs++;
        if (nfs == 2) check("s_frame_period_clks", cyc - last, S_HT * S_VT * S_DIV);
        last = cyc;
`ifdef VGA_FRAME_CNT_EN
        if (nfs == 255) check("s_frame_cnt_255", fc_s, 255);
`else
        if (nfs == 255) check("s_frame_cnt_off", fc_s, 0);
`endif
        if (nfs == 256) begin
          check("s_frame_cnt_wrap", fc_s, 0);
          break;
        end
      end
    end
    if (k == 70000) timeout("s_frames_wait");
  endtask

  task automatic run_tiny();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("t_pix_tick_continuous", pt_t, 1);
      check("t_h_cnt_step", h_t, i % 7);
    end
  endtask

  initial begin
    rst_d = 1'b1; en_d = 1'b1;
    rst_s = 1'b1; en_s = 1'b1;
    rst_t = 1'b1; en_t = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_d("reset");
    check("t_reset_pix_tick", pt_t, 0);
    @(posedge clk);
    #1;
    rst_d = 1'b0;
    rst_s = 1'b0;
    rst_t = 1'b0;
    fork
      run_default();
      run_small();
      run_tiny();
    join
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
